lsu_stage: RTL and testbench
============================

Name: lsu_stage

Overview:
- Load/store stage directly downstream of the execute ALU. It consumes the ALU result as an effective address, or as a pass-through value for non-memory ops.
- Issues one data-memory request per op over a valid/ready request channel and waits for the response.
- Aligns and extends load data, then presents the writeback value to the next stage over a valid/ready output handshake.
- Single-entry, non-pipelined: at most one op in flight.

Parameters:
TIMEOUT, 255, cycles to wait in WAIT for mem_resp_valid before aborting; 0 disables the timeout.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  upstream op valid
in_ready  out  1  stage can accept an op
in_addr  in  32  ALU result: effective address, or the result itself for non-memory ops
in_wdata  in  32  store data (rs2)
in_fun  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
in_is_load  in  1  op is a load
in_is_store  in  1  op is a store
in_rd  in  5  destination register
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  32  word-aligned address ({addr[31:2],2'b00})
mem_req_we  out  1  1 = write
mem_req_wstrb  out  4  byte enables
mem_req_wdata  out  32  lane-replicated store data
mem_resp_valid  in  1  load response valid
mem_resp_data  in  32  load response word
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  32  writeback value
out_rd  out  5  destination register
out_misaligned  out  1  op aborted: misaligned access
out_timeout  out  1  op aborted: response timeout

Behaviour:
- Clock is clk; reset is synchronous and active-high. All state updates occur on rising clk.
- Reset forces state IDLE and all registered outputs to 0: mem_req_valid, out_valid, out_data, out_rd, out_misaligned, out_timeout, mem_req_*. Counter is cleared.
- Reset mid-operation drops the in-flight op silently. A memory response arriving after reset is ignored.
- FSM states: IDLE, REQ, WAIT, DONE. in_ready = (state==IDLE).
- IDLE, on in_valid:
  - Latch all in_* fields.
  - If neither in_is_load nor in_is_store, go to DONE with out_data=in_addr.
  - Else if misaligned, go to DONE with out_misaligned=1, out_data=0, and no memory request.
  - Else go to REQ.
- If in_is_load and in_is_store are both 1, treat as a load.
- Misaligned means: H/HU with addr[0]=1, or W with addr[1:0]!=0. Reserved funct3 encodings are treated as W.
- REQ: mem_req_valid=1; request fields are stable until accepted. On mem_req_ready, a store goes to DONE with out_data=0, and a load goes to WAIT with the counter cleared.
- Store encoding:
  - B: wstrb = 4'b0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - H: wstrb = 4'b0011<<addr[1:0], wdata = {2{wdata[15:0]}}.
  - W: wstrb = 4'b1111, wdata = wdata.
  - Loads drive wstrb=0 and we=0.
- WAIT: on mem_resp_valid, go to DONE. The selected lane is mem_resp_data >> (8*addr[1:0]).
  - B sign-extends bits [7:0]; BU zero-extends [7:0].
  - H sign-extends [15:0]; HU zero-extends [15:0]; W passes the word.
- WAIT timeout: the counter increments each WAIT cycle. If TIMEOUT!=0 and the counter reaches TIMEOUT with no response, go to DONE with out_timeout=1, out_data=0.
  - A response in the same cycle as expiry wins: no timeout is flagged.
- mem_resp_valid outside WAIT is ignored.
- DONE: out_valid=1; outputs are held stable until out_ready. On out_ready, go to IDLE and clear out_valid and the flags.
  - No new op is accepted in the DONE cycle, so the ALU pass-through throughput is 1 op per 2 cycles.
- Latency, accept edge to out_valid:
  - Non-memory op: 1 cycle.
  - Store: 1 + request wait cycles + 1.
  - Load: additionally includes the response wait.

Optional Feature:
LSU_MISALIGN_CHECK_EN
- Defined: misalignment is detected and aborted as above.
- Undefined: no check; out_misaligned is tied 0. All accesses issue with the word-aligned address.
  - Lane select and wstrb still use addr[1:0] as given, with shifted bits beyond the word truncated.

Test Plan:
- ALU op: in_addr=0x0000_1234, no load/store -> out_valid 1 cycle later, out_data=0x1234, no mem_req_valid ever.
- LB at 0x103, mem_resp_data=0x80FF_FFFF -> mem_req_addr=0x100, out_data=0xFFFF_FF80. LBU at the same address -> 0x0000_0080.
- SH at 0x202, wdata=0x1234_ABCD, mem_req_ready held 0 for 3 cycles -> request fields stable throughout, wstrb=4'b1100, wdata=0xABCD_ABCD, out_valid after acceptance.
- LW at 0x301 with the macro defined -> no request, out_misaligned=1. With the macro undefined -> request to 0x300.
- LW with TIMEOUT=4 and no response -> out_timeout=1 after 4 WAIT cycles. Repeat with the response arriving in cycle 4 -> normal data, out_timeout=0.
- Reset asserted in WAIT, then a stale mem_resp_valid arrives -> state IDLE, in_ready=1, out_valid stays 0.

Source files
------------

// File: rtl/lsu_stage.sv
// Load/store stage: one op in flight, word-aligned memory requests, load extension.
// Optional misalignment abort enabled by LSU_MISALIGN_CHECK_EN.
module lsu_stage #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic [2:0]  in_fun,
   input  logic        in_is_load,
   input  logic        in_is_store,
   input  logic [4:0]  in_rd,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   output logic        mem_req_we,
   output logic [3:0]  mem_req_wstrb,
   output logic [31:0] mem_req_wdata,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [4:0]  out_rd,
   output logic        out_misaligned,
   output logic        out_timeout
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t      state_q, state_d;
   logic [1:0]  off_q, off_d;
   logic [2:0]  fun_q, fun_d;
   logic        load_q, load_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] data_q, data_d;
   logic        mis_q, mis_d;
   logic        to_q, to_d;
   logic [31:0] raddr_q, raddr_d;
   logic        rwe_q, rwe_d;
   logic [3:0]  rstrb_q, rstrb_d;
   logic [31:0] rwdata_q, rwdata_d;

   logic        is_b, is_h, misaligned;
   logic [3:0]  st_strb;
   logic [31:0] st_wdata, lane, ld_data;

   assign is_b = (in_fun[1:0] == 2'b00);
   assign is_h = (in_fun[1:0] == 2'b01);

`ifdef LSU_MISALIGN_CHECK_EN
   assign misaligned = (is_h & in_addr[0]) |
                       (~is_b & ~is_h & (|in_addr[1:0]));
`else
   assign misaligned = 1'b0;
`endif

   always_comb begin
      st_strb  = 4'b1111;
      st_wdata = in_wdata;
      unique case (1'b1)
         is_b: begin
            st_strb  = 4'b0001 << in_addr[1:0];
            st_wdata = {4{in_wdata[7:0]}};
         end
         is_h: begin
            st_strb  = 4'b0011 << in_addr[1:0];
            st_wdata = {2{in_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // fun_q[2] selects zero extension for BU/HU
   assign lane = mem_resp_data >> {off_q, 3'b000};

   always_comb begin
      ld_data = lane;
      unique case (fun_q[1:0])
         2'b00:   ld_data = {{24{~fun_q[2] & lane[7]}}, lane[7:0]};
         2'b01:   ld_data = {{16{~fun_q[2] & lane[15]}}, lane[15:0]};
         default: ld_data = lane;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      off_d    = off_q;
      fun_d    = fun_q;
      load_d   = load_q;
      rd_d     = rd_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      mis_d    = mis_q;
      to_d     = to_q;
      raddr_d  = raddr_q;
      rwe_d    = rwe_q;
      rstrb_d  = rstrb_q;
      rwdata_d = rwdata_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               off_d  = in_addr[1:0];
               fun_d  = in_fun;
               load_d = in_is_load;
               rd_d   = in_rd;
               if (!in_is_load && !in_is_store) begin
                  data_d  = in_addr;
                  state_d = DONE;
               end else if (misaligned) begin
                  mis_d   = 1'b1;
                  data_d  = 32'd0;
                  state_d = DONE;
               end else begin
                  raddr_d  = {in_addr[31:2], 2'b00};
                  rwe_d    = ~in_is_load;
                  rstrb_d  = in_is_load ? 4'b0000 : st_strb;
                  rwdata_d = st_wdata;
                  state_d  = REQ;
               end
            end
         end
         REQ: begin
            if (mem_req_ready) begin
               if (load_q) begin
                  cnt_d   = 32'd0;
                  state_d = WAIT;
               end else begin
                  data_d  = 32'd0;
                  state_d = DONE;
               end
            end
         end
         WAIT: begin
            if (mem_resp_valid) begin
               data_d  = ld_data;
               state_d = DONE;
            end else if (TIMEOUT != 0 && cnt_q + 32'd1 == TIMEOUT) begin
               to_d    = 1'b1;
               data_d  = 32'd0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         DONE: begin
            if (out_ready) begin
               mis_d   = 1'b0;
               to_d    = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         off_q    <= 2'd0;
         fun_q    <= 3'd0;
         load_q   <= 1'b0;
         rd_q     <= 5'd0;
         cnt_q    <= 32'd0;
         data_q   <= 32'd0;
         mis_q    <= 1'b0;
         to_q     <= 1'b0;
         raddr_q  <= 32'd0;
         rwe_q    <= 1'b0;
         rstrb_q  <= 4'd0;
         rwdata_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         off_q    <= off_d;
         fun_q    <= fun_d;
         load_q   <= load_d;
         rd_q     <= rd_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         mis_q    <= mis_d;
         to_q     <= to_d;
         raddr_q  <= raddr_d;
         rwe_q    <= rwe_d;
         rstrb_q  <= rstrb_d;
         rwdata_q <= rwdata_d;
      end
   end

   assign in_ready       = (state_q == IDLE);
   assign mem_req_valid  = (state_q == REQ);
   assign mem_req_addr   = raddr_q;
   assign mem_req_we     = rwe_q;
   assign mem_req_wstrb  = rstrb_q;
   assign mem_req_wdata  = rwdata_q;
   assign out_valid      = (state_q == DONE);
   assign out_data       = data_q;
   assign out_rd         = rd_q;
   assign out_misaligned = mis_q;
   assign out_timeout    = to_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed table-driven bench for lsu_stage, built with a short response timeout.
module tb_lsu_stage;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_addr;
   logic [31:0] in_wdata;
   logic [2:0]  in_fun;
   logic        in_is_load;
   logic        in_is_store;
   logic [4:0]  in_rd;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_req_we;
   logic [3:0]  mem_req_wstrb;
   logic [31:0] mem_req_wdata;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_rd;
   logic        out_misaligned;
   logic        out_timeout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lsu_stage #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_wdata(in_wdata), .in_fun(in_fun),
      .in_is_load(in_is_load), .in_is_store(in_is_store), .in_rd(in_rd),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
      .mem_req_wstrb(mem_req_wstrb), .mem_req_wdata(mem_req_wdata),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_rd(out_rd),
      .out_misaligned(out_misaligned), .out_timeout(out_timeout)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  fun;
      logic        ld;
      logic        st;
      logic [4:0]  rd;
      int          req_wait;
      int          resp_wait;
      bit          respond;
      logic [31:0] resp;
      bit          exp_req;
      logic [31:0] exp_addr;
      logic        exp_we;
      logic [3:0]  exp_strb;
      logic [31:0] exp_wdata;
      logic [31:0] exp_data;
      bit          chk_data;
      logic        exp_mis;
      logic        exp_to;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string n, input logic [31:0] a,
                      input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", n, a, e);
      end
   endtask

   function automatic vec_t mk(
      input logic [31:0] addr, input logic [31:0] wdata,
      input logic [2:0] fun, input logic ld, input logic st,
      input logic [4:0] rd, input int req_wait, input int resp_wait,
      input bit respond, input logic [31:0] resp, input bit exp_req,
      input logic [31:0] exp_addr, input logic exp_we,
      input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
      input logic [31:0] exp_data, input bit chk_data,
      input logic exp_mis, input logic exp_to);
      vec_t v;
      v.addr = addr; v.wdata = wdata; v.fun = fun;
      v.ld = ld; v.st = st; v.rd = rd;
      v.req_wait = req_wait; v.resp_wait = resp_wait;
      v.respond = respond; v.resp = resp;
      v.exp_req = exp_req; v.exp_addr = exp_addr;
      v.exp_we = exp_we; v.exp_strb = exp_strb;
      v.exp_wdata = exp_wdata; v.exp_data = exp_data;
      v.chk_data = chk_data; v.exp_mis = exp_mis; v.exp_to = exp_to;
      return v;
   endfunction

   task automatic run(input vec_t v);
      int n;
      @(negedge clk);
      chk("in_ready_idle", in_ready, 1);
      in_valid    = 1'b1;
      in_addr     = v.addr;
      in_wdata    = v.wdata;
      in_fun      = v.fun;
      in_is_load  = v.ld;
      in_is_store = v.st;
      in_rd       = v.rd;
      @(negedge clk);
      in_valid = 1'b0;
      if (!v.exp_req) begin
         chk("no_req", mem_req_valid, 0);
      end else begin
         for (int k = 0; k <= v.req_wait; k++) begin
            chk("req_valid", mem_req_valid, 1);
            chk("req_addr", mem_req_addr, v.exp_addr);
            chk("req_we", mem_req_we, v.exp_we);
            chk("req_wstrb", mem_req_wstrb, v.exp_strb);
            if (v.exp_we) chk("req_wdata", mem_req_wdata, v.exp_wdata);
            chk("busy_req", out_valid, 0);
            mem_req_ready = (k == v.req_wait);
            @(negedge clk);
         end
         mem_req_ready = 1'b0;
         if (!v.exp_we) begin
            n = v.respond ? v.resp_wait : TO;
            for (int k = 0; k < n; k++) begin
               chk("busy_wait", out_valid, 0);
               chk("wait_noreq", mem_req_valid, 0);
               @(negedge clk);
            end
            if (v.respond) begin
               mem_resp_valid = 1'b1;
               mem_resp_data  = v.resp;
               chk("busy_resp", out_valid, 0);
               @(negedge clk);
               mem_resp_valid = 1'b0;
               mem_resp_data  = 32'h0;
            end
         end
      end
      chk("out_valid", out_valid, 1);
      if (v.chk_data) chk("out_data", out_data, v.exp_data);
      chk("out_rd", out_rd, v.rd);
      chk("out_mis", out_misaligned, v.exp_mis);
      chk("out_to", out_timeout, v.exp_to);
      chk("done_noreq", mem_req_valid, 0);
      chk("done_busy", in_ready, 0);
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      if (v.chk_data) chk("hold_data", out_data, v.exp_data);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("drain_valid", out_valid, 0);
      chk("drain_ready", in_ready, 1);
      chk("drain_mis", out_misaligned, 0);
      chk("drain_to", out_timeout, 0);
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0; in_addr = 32'h0; in_wdata = 32'h0; in_fun = 3'h0;
      in_is_load = 1'b0; in_is_store = 1'b0; in_rd = 5'h0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
      out_ready = 1'b0;

      // ALU pass-through
      vecs.push_back(mk(32'h0000_1234, 0, 3'b000, 0, 0, 5'd5, 0, 0, 0, 0,
         0, 0, 0, 0, 0, 32'h0000_1234, 1, 0, 0));
      // LB / LBU at 0x103
      vecs.push_back(mk(32'h0000_0103, 0, 3'b000, 1, 0, 5'd6, 0, 0, 1,
         32'h80FF_FFFF, 1, 32'h100, 0, 4'b0000, 0, 32'hFFFF_FF80, 1, 0, 0));
      vecs.push_back(mk(32'h0000_0103, 0, 3'b100, 1, 0, 5'd7, 1, 2, 1,
         32'h80FF_FFFF, 1, 32'h100, 0, 4'b0000, 0, 32'h0000_0080, 1, 0, 0));
      // SH at 0x202, request stalled 3 cycles
      vecs.push_back(mk(32'h0000_0202, 32'h1234_ABCD, 3'b001, 0, 1, 5'd8,
         3, 0, 0, 0, 1, 32'h200, 1, 4'b1100, 32'hABCD_ABCD, 0, 1, 0, 0));
      // LH / LHU at 0x102
      vecs.push_back(mk(32'h0000_0102, 0, 3'b001, 1, 0, 5'd9, 0, 1, 1,
         32'h80FF_1234, 1, 32'h100, 0, 4'b0000, 0, 32'hFFFF_80FF, 1, 0, 0));
      vecs.push_back(mk(32'h0000_0102, 0, 3'b101, 1, 0, 5'd10, 0, 0, 1,
         32'h80FF_1234, 1, 32'h100, 0, 4'b0000, 0, 32'h0000_80FF, 1, 0, 0));
      // LW aligned
      vecs.push_back(mk(32'h0000_0300, 0, 3'b010, 1, 0, 5'd11, 2, 0, 1,
         32'hDEAD_BEEF, 1, 32'h300, 0, 4'b0000, 0, 32'hDEAD_BEEF, 1, 0, 0));
      // SB at 0x401, SW at 0x500
      vecs.push_back(mk(32'h0000_0401, 32'h0000_00A5, 3'b000, 0, 1, 5'd12,
         0, 0, 0, 0, 1, 32'h400, 1, 4'b0010, 32'hA5A5_A5A5, 0, 1, 0, 0));
      vecs.push_back(mk(32'h0000_0500, 32'hCAFE_F00D, 3'b010, 0, 1, 5'd13,
         1, 0, 0, 0, 1, 32'h500, 1, 4'b1111, 32'hCAFE_F00D, 0, 1, 0, 0));
      // load and store both set behaves as a load
      vecs.push_back(mk(32'h0000_0100, 32'hFFFF_FFFF, 3'b010, 1, 1, 5'd14,
         0, 0, 1, 32'h1122_3344, 1, 32'h100, 0, 4'b0000, 0,
         32'h1122_3344, 1, 0, 0));
      // LBU byte 2, rd 31
      vecs.push_back(mk(32'h0000_0002, 0, 3'b100, 1, 0, 5'd31, 0, 0, 1,
         32'h00AB_0000, 1, 32'h0, 0, 4'b0000, 0, 32'h0000_00AB, 1, 0, 0));
`ifdef LSU_MISALIGN_CHECK_EN
      vecs.push_back(mk(32'h0000_0301, 0, 3'b010, 1, 0, 5'd15, 0, 0, 0, 0,
         0, 0, 0, 0, 0, 32'h0, 1, 1, 0));
      vecs.push_back(mk(32'h0000_0203, 32'h1234_5678, 3'b001, 0, 1, 5'd16,
         0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1, 0));
`else
      vecs.push_back(mk(32'h0000_0301, 0, 3'b010, 1, 0, 5'd15, 0, 0, 1,
         32'h1122_3344, 1, 32'h300, 0, 4'b0000, 0, 0, 0, 0, 0));
      vecs.push_back(mk(32'h0000_0203, 32'h1234_5678, 3'b001, 0, 1, 5'd16,
         0, 0, 0, 0, 1, 32'h200, 1, 4'b1000, 32'h5678_5678, 0, 1, 0, 0));
`endif
      // timeout after TO WAIT cycles, then a response in the last cycle wins
      vecs.push_back(mk(32'h0000_0400, 0, 3'b010, 1, 0, 5'd17, 0, 0, 0, 0,
         1, 32'h400, 0, 4'b0000, 0, 32'h0, 1, 0, 1));
      vecs.push_back(mk(32'h0000_0400, 0, 3'b010, 1, 0, 5'd18, 0, TO - 1, 1,
         32'h5555_AAAA, 1, 32'h400, 0, 4'b0000, 0, 32'h5555_AAAA, 1, 0, 0));

      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_req_valid", mem_req_valid, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_rd", out_rd, 0);
      chk("rst_mis", out_misaligned, 0);
      chk("rst_to", out_timeout, 0);
      chk("rst_req_addr", mem_req_addr, 0);
      chk("rst_req_we", mem_req_we, 0);
      chk("rst_req_wstrb", mem_req_wstrb, 0);
      chk("rst_req_wdata", mem_req_wdata, 0);

      foreach (vecs[i]) run(vecs[i]);

      // ALU throughput: back-to-back ops accepted every other cycle
      @(negedge clk);
      in_valid = 1'b1; in_is_load = 1'b0; in_is_store = 1'b0;
      in_addr = 32'hAAAA_0001; in_rd = 5'd1; out_ready = 1'b1;
      @(negedge clk);
      chk("tp_valid0", out_valid, 1);
      chk("tp_data0", out_data, 32'hAAAA_0001);
      chk("tp_busy", in_ready, 0);
      in_addr = 32'hAAAA_0002; in_rd = 5'd2;
      @(negedge clk);
      chk("tp_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("tp_valid1", out_valid, 1);
      chk("tp_data1", out_data, 32'hAAAA_0002);
      chk("tp_rd1", out_rd, 2);
      @(negedge clk);
      out_ready = 1'b0;
      chk("tp_drain", in_ready, 1);

      // reset while waiting for a load response, then a stale response
      in_valid = 1'b1; in_is_load = 1'b1; in_fun = 3'b010;
      in_addr = 32'h0000_0700; in_rd = 5'd20;
      @(negedge clk);
      in_valid = 1'b0;
      chk("rw_req", mem_req_valid, 1);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      chk("rw_wait", in_ready, 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h1234_5678;
      chk("rw_in_ready", in_ready, 1);
      @(negedge clk);
      mem_resp_valid = 1'b0;
      chk("rw_ready2", in_ready, 1);
      chk("rw_out_valid", out_valid, 0);
      chk("rw_out_data", out_data, 0);
      chk("rw_req_valid", mem_req_valid, 0);
      @(negedge clk);
      chk("rw_out_valid2", out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
